dm_arb: RTL
===========

Name: dm_arb

Overview:
- Two-port arbiter and sequencer in front of the 1 KB data memory, which has a 32-bit word port, a single write enable, and a combinational read.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Performs round-robin arbitration, word reads, and full-word writes.
- Byte-enable partial writes (sb/sh) are done as a read-modify-write, so the memory itself needs no byte lanes.

Parameters:
AW, 10, byte address width of the memory
DW, 32, data width (fixed 4 byte lanes)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-high reset
req0  in  1  port 0 request, held until ack0
we0  in  1  port 0 write (1) / read (0)
be0  in  4  port 0 byte enables, be0[i] -> bits 8i+7:8i
addr0  in  AW  port 0 byte address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 done, one-cycle pulse
req1, we1, be1, addr1, wdata1, ack1  same as port 0, for port 1
rdata  out  DW  read data, valid in the ack cycle
busy  out  1  transaction in progress (state != IDLE)
mem_addr  out  AW  memory address, bits [1:0] always 0
mem_wdata  out  DW  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DW  memory combinational read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last-grant=1 (port 0 wins the first tie).
  - Latched addr/wdata/be/we/owner = 0; rdata=0; ack0=ack1=0; mem_we=0; busy=0.
  - Reset mid-transaction aborts it: no ack, mem_we drops immediately, no partial write after reset.
- States and transitions:
  - IDLE: if any req, select owner and latch {addr, wdata, be, we}; -> ACCESS.
    - Only req0 -> port 0. Only req1 -> port 1.
    - Both -> the port not equal to last-grant; last-grant updates on selection.
  - ACCESS: mem_addr = {addr[AW-1:2], 2'b00}.
    - Read: rdata <= mem_rdata; -> DONE.
    - Write, be==4'b1111: mem_we=1, mem_wdata=wdata; -> DONE.
    - Write, be==0: no memory write; -> DONE (acked no-op).
    - Write, other be: merge register <= per byte i, be[i] ? wdata byte i : mem_rdata byte i; -> MERGE.
  - MERGE: mem_we=1, mem_wdata=merge register, same mem_addr; -> DONE.
  - DONE: ack[owner]=1 for exactly one cycle; rdata held stable (and kept after ack until the next read completes); -> IDLE.
- Latency, counting the cycle req is first sampled in IDLE as cycle 0:
  - read, full write, no-op: ack in cycle 2.
  - partial write: ack in cycle 3.
  - Max throughput: one transaction per 3 cycles (4 for a partial write).
- Handshake:
  - Requester holds req and its inputs until ack.
  - Inputs are latched at grant, so later changes do not affect the current transaction.
  - req dropped before ack: the transaction still completes and ack still pulses.
  - req held high in the ack cycle: seen as a new request in the next IDLE.
- mem_we is combinational from state and latched fields, high only in ACCESS (full write) or MERGE. The write commits at the posedge ending that cycle.
- addr[1:0] is ignored (word-aligned accesses only).
- ack0 and ack1 are never high together.
- busy = (state != IDLE).

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins a tie; last-grant register removed.
- Undefined: round-robin as described above.

Decomposition:
- Package dm_arb_pkg:
  - state encoding (IDLE, ACCESS, MERGE, DONE)
  - AW/DW defaults
  - BE_FULL = 4'b1111, BE_NONE = 4'b0000
- Sub-module dm_byte_merge: combinational, inputs (old, new, be), output merged word. Reused by any future byte-lane logic.

Test Plan:
- Reset values: assert rst mid-MERGE -> mem_we=0 at once, no ack, state IDLE; memory word unchanged.
- Full write then read:
  - Port 0 writes 0xDEADBEEF to addr 0x010, be=1111 -> mem_we high for exactly 1 cycle, ack0 in cycle 2.
  - Port 0 reads 0x010 -> rdata=0xDEADBEEF with ack0 in cycle 2.
- Partial write:
  - Memory word at 0x020 is 0x11223344.
  - Port 1 writes wdata=0xAABBCCDD, be=0101 -> memory becomes 0x11BB33DD, ack1 in cycle 3, one mem_we pulse.
- Round-robin: req0 and req1 held high continuously -> grants alternate 0,1,0,1 starting with 0; no ack overlap. With DM_ARB_FIXED_PRIO_EN -> port 0 only.
- Edge cases:
  - be=0000 write -> ack in cycle 2, mem_we never asserted.
  - addr 0x013 read -> mem_addr=0x010.
  - req0 dropped after 1 cycle -> ack0 still pulses.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the dm_arb data-memory arbiter: FSM states,
// default widths and the byte-enable patterns that select the write path.
package dm_arb_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/dm_arb_if.sv
// Bundle of the two requester ports and the data-memory port of dm_arb.
// slave = arbiter side, master = requesters plus the memory model.
interface dm_arb_if
    import dm_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          req0;
    logic          we0;
    logic [3:0]    be0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;

    logic          req1;
    logic          we1;
    logic [3:0]    be1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;

    logic [DW-1:0] rdata;
    logic          busy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, we0, be0, addr0, wdata0,
        input  req1, we1, be1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata, busy,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, we0, be0, addr0, wdata0,
        output req1, we1, be1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata, busy,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new byte,
// every other lane keeps the old one.
module dm_byte_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_i,
    input  logic [DW-1:0]   new_i,
    input  logic [DW/8-1:0] be_i,
    output logic [DW-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < DW / 8; i++) begin
            if (be_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_arb.sv
// Two-port round-robin arbiter/sequencer for the data memory; partial writes
// become read-modify-write. Define DM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic     clk,
    input logic     rst,
    dm_arb_if.slave bus
);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:2] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] merge_q, merge_d;
    logic [DW-1:0] merged;
    logic          sel;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign sel = ~bus.req0;
`else
    logic last_q, last_d;

    // On a tie the port that did not win last time is chosen.
    assign sel = (bus.req0 & bus.req1) ? ~last_q : ~bus.req0;
`endif

    dm_byte_merge #(.DW(DW)) u_merge (
        .old_i    (bus.mem_rdata),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged)
    );

    assign bus.mem_addr = {addr_q, 2'b00};
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.rdata    = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        be_d          = be_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        merge_d       = merge_q;
`ifndef DM_ARB_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        bus.mem_we    = 1'b0;
        bus.mem_wdata = wdata_q;
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = sel;
                    we_d    = sel ? bus.we1 : bus.we0;
                    be_d    = sel ? bus.be1 : bus.be0;
                    addr_d  = sel ? bus.addr1[AW-1:2] : bus.addr0[AW-1:2];
                    wdata_d = sel ? bus.wdata1 : bus.wdata0;
`ifndef DM_ARB_FIXED_PRIO_EN
                    last_d  = sel;
`endif
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                if (!we_q) begin
                    rdata_d = bus.mem_rdata;
                end else if (be_q == BE_FULL) begin
                    bus.mem_we = 1'b1;
                end else if (be_q != BE_NONE) begin
                    merge_d = merged;
                    state_d = ST_MERGE;
                end
            end
            ST_MERGE: begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = merge_q;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                bus.ack0 = ~owner_q;
                bus.ack1 = owner_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
